// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out.
// One right shift per SHIFT cycle, then a subtract-3 fix on one digit per SUB cycle.
module bcd_to_binary #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_d_in,
  output logic [BIN_W-1:0]      bin_d_out,
  output logic                  rdy,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned WRK_W = BCD_W + BIN_W;
  localparam int unsigned SH_W  = (BIN_W  > 1) ? $clog2(BIN_W)  : 1;
  localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(BIN_W - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  // ERR exists so an invalid input still reports one edge after acceptance
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    SUB   = 3'd2,
    ERR   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [WRK_W-1:0]   w;
  logic [WRK_W-1:0]   w_shr;
  logic [WRK_W-1:0]   w_fix;
  logic [SH_W-1:0]    sh_cnt;
  logic [DIG_W-1:0]   dig_cnt;
  logic               in_bad;

  // Any input digit above 9 makes the whole word invalid
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_d_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  assign w_shr = w >> 1;

  // Correct only the digit selected by dig_cnt; no borrow crosses digits
  always_comb begin
    w_fix = w;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((dig_cnt == DIG_W'(i)) && (w[BIN_W + 4*i +: 4] >= 4'd8)) begin
        w_fix[BIN_W + 4*i +: 4] = w[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      sh_cnt    <= '0;
      dig_cnt   <= '0;
      bin_d_out <= '0;
      rdy       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy  <= 1'b0;
          busy <= 1'b0;
          if (en) begin
            busy <= 1'b1;
            if (in_bad) begin
              err       <= 1'b1;
              bin_d_out <= '0;
              state     <= ERR;
            end else begin
              w      <= {bcd_d_in, {BIN_W{1'b0}}};
              sh_cnt <= '0;
              err    <= 1'b0;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          w <= w_shr;
          if (sh_cnt == SH_LAST) begin
            bin_d_out <= w_shr[BIN_W-1:0];
            rdy       <= 1'b1;
            state     <= DONE;
          end else begin
            sh_cnt  <= sh_cnt + SH_W'(1);
            dig_cnt <= '0;
            state   <= SUB;
          end
        end
        SUB: begin
          w       <= w_fix;
          dig_cnt <= dig_cnt + DIG_W'(1);
          if (dig_cnt == DIG_LAST) state <= SHIFT;
        end
        ERR: begin
          rdy   <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          rdy   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rdy   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases plus random BCD words
// compared against a decimal-arithmetic reference.
module tb_bcd_to_binary;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;
  localparam int          LAT_OK  = BIN_W + (BIN_W - 1) * DIGITS;
  localparam int          LAT_BAD = 1;
  localparam int          WAIT_MAX = 300;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [4*DIGITS-1:0]  bcd_d_in;
  logic [BIN_W-1:0]     bin_d_out;
  logic                 rdy;
  logic                 err;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: decimal value of the digits, or invalid if any digit exceeds 9
  function automatic void ref_model(input logic [4*DIGITS-1:0] v, output int val, output bit bad);
    int scale;
    int d;
    val = 0;
    bad = 0;
    scale = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) bad = 1;
      val = val + d * scale;
      scale = scale * 10;
    end
    if (bad) val = 0;
  endfunction

  // Accept one word, wait for rdy, check result, latency, busy and pulse width
  task automatic convert(input string tag, input logic [4*DIGITS-1:0] v, input bit scramble);
    int  exp_val;
    bit  exp_bad;
    int  k;
    bit  busy_ok;
    logic [BIN_W-1:0] res;
    ref_model(v, exp_val, exp_bad);
    @(negedge clk);
    bcd_d_in = v;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    while (k < WAIT_MAX) begin
      @(posedge clk);
      #1;
      k++;
      if (rdy) break;
      if (!busy) busy_ok = 1'b0;
      if (scramble) begin
        en = 1'($urandom);
        bcd_d_in = 16'($urandom);
      end
    end
    en = 1'b0;
    check({tag, " latency"}, 32'(k), 32'(exp_bad ? LAT_BAD : LAT_OK));
    check({tag, " result"}, 32'(bin_d_out), 32'(exp_val));
    check({tag, " err"}, 32'(err), 32'(exp_bad));
    check({tag, " busy"}, 32'({busy_ok, busy}), 32'(2'b11));
    res = bin_d_out;
    @(posedge clk);
    #1;
    check({tag, " rdy one cycle"}, 32'({rdy, busy}), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold"}, 32'({err, bin_d_out}), 32'({exp_bad, res}));
  endtask

  initial begin
    int  k;
    int  v1;
    bit  b1;
    logic [4*DIGITS-1:0] rv;

    rst = 1'b1;
    en = 1'b0;
    bcd_d_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 32'({bin_d_out, rdy, err, busy}), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    convert("zero", 16'h0000, 0);
    convert("max", 16'h9999, 0);

    // Back-to-back with en held: second accept two edges after first rdy
    @(negedge clk);
    bcd_d_in = 16'h1234;
    en = 1'b1;
    @(posedge clk);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!rdy && k < WAIT_MAX);
    check("b2b first latency", 32'(k), 32'(LAT_OK));
    check("b2b first result", 32'(bin_d_out), 32'(1234));
    bcd_d_in = 16'h0100;
    @(posedge clk);
    #1;
    check("b2b first rdy width", 32'(rdy), 32'(0));
    k = 1;
    do begin @(posedge clk); #1; k++; end while (!rdy && k < WAIT_MAX);
    en = 1'b0;
    check("b2b gap", 32'(k), 32'(LAT_OK + 2));
    check("b2b second result", 32'(bin_d_out), 32'(100));
    @(posedge clk);
    #1;
    check("b2b second rdy width", 32'(rdy), 32'(0));

    convert("invalid", 16'h12A4, 0);
    convert("after invalid", 16'h0007, 0);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    bcd_d_in = 16'h5678;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async reset", 32'({bin_d_out, rdy, err, busy}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    b1 = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (rdy || busy) b1 = 1'b1;
    end
    check("no rdy after abort", 32'(b1), 32'(0));
    convert("post reset", 16'h0042, 0);

    convert("scramble during busy", 16'h3071, 1);
    convert("scramble invalid", 16'hF000, 1);

    // Random words, mostly valid BCD
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rv = 16'($urandom);
      end else begin
        for (int j = 0; j < int'(DIGITS); j++) rv[4*j +: 4] = 4'($urandom_range(0, 9));
      end
      ref_model(rv, v1, b1);
      convert($sformatf("rand%0d_%h", i, rv), rv, i[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
